forest_vote_accum: RTL and testbench



---
 rtl/forest_pkg.sv | 22 ++
 rtl/forest_seq_argmax.sv | 63 ++++++
 rtl/forest_vote_accum.sv | 84 ++++++++
 tb/tb_forest_vote_accum.sv | 122 ++++++++++++
 4 files changed

// File: rtl/forest_pkg.sv
// Shared constants and helpers for the decision-forest vote path.
// The tree-instance wrapper reuses the same class/tree geometry.
package forest_pkg;
  localparam int NUM_CLASSES = 5;
  localparam int NUM_TREES   = 4;
  localparam int CNT_W       = $clog2(NUM_TREES + 1);
  localparam int CLS_W       = $clog2(NUM_CLASSES);
  localparam int T_W         = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
  localparam int VOTES_W     = NUM_CLASSES * NUM_TREES;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } fsm_state_e;

  // Flat position of the vote from tree t of class c.
  function automatic int vote_idx(input int c, input int t);
    return c * NUM_TREES + t;
  endfunction
endpackage

// File: rtl/forest_seq_argmax.sv
// Sequential argmax over the per-class counters, one class per clock.
// Ties keep the lowest index and raise the tie flag.
module forest_seq_argmax
  import forest_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [NUM_CLASSES-1:0][CNT_W-1:0]     cnt,
  output logic [CLS_W-1:0]                      res_class,
  output logic [CNT_W-1:0]                      res_votes,
  output logic                                  res_tie,
  output logic                                  done
);
  logic             busy;
  logic [CLS_W-1:0] k;
  logic [CNT_W-1:0] best, n_best, cur;
  logic [CLS_W-1:0] best_idx, n_idx;
  logic             tie_q, n_tie;

  always_comb begin
    cur    = cnt[k];
    n_best = best;
    n_idx  = best_idx;
    n_tie  = tie_q;
    if (k == '0) begin
      n_best = cur;
      n_idx  = '0;
      n_tie  = 1'b0;
    end else if (cur > best) begin
      n_best = cur;
      n_idx  = k;
      n_tie  = 1'b0;
    end else if (cur == best) begin
      n_tie  = 1'b1;
    end
  end

  // Results are the post-update values so the caller can load them on the last step.
  assign done      = busy && (k == CLS_W'(NUM_CLASSES - 1));
  assign res_class = n_idx;
  assign res_votes = n_best;
  assign res_tie   = n_tie;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      k        <= '0;
      best     <= '0;
      best_idx <= '0;
      tie_q    <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      k    <= '0;
    end else if (busy) begin
      best     <= n_best;
      best_idx <= n_idx;
      tie_q    <= n_tie;
      k        <= k + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/forest_vote_accum.sv
// Captures the forest vote vector, counts votes per class serially over
// trees, then hands the counters to the sequential argmax.
module forest_vote_accum
  import forest_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VOTES_W-1:0] in_votes,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLS_W-1:0]   out_class,
  output logic [CNT_W-1:0]   out_votes,
  output logic               out_tie,
  output logic               out_none
);
  fsm_state_e                          state;
  logic [VOTES_W-1:0]                  votes_q;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]   cnt;
  logic [T_W-1:0]                      t;
  logic                                am_start, am_done, am_tie;
  logic [CLS_W-1:0]                    am_class;
  logic [CNT_W-1:0]                    am_votes;

  // The last COUNT edge arms the argmax so it starts on the settled counters.
  assign am_start = (state == ST_COUNT) && (t == T_W'(NUM_TREES - 1));

  forest_seq_argmax u_argmax (
    .clk       (clk),
    .rst       (rst),
    .start     (am_start),
    .cnt       (cnt),
    .res_class (am_class),
    .res_votes (am_votes),
    .res_tie   (am_tie),
    .done      (am_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_class <= '0;
      out_votes <= '0;
      out_tie   <= 1'b0;
      out_none  <= 1'b0;
      votes_q   <= '0;
      cnt       <= '0;
      t         <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          votes_q  <= in_votes;
          cnt      <= '0;
          t        <= '0;
          in_ready <= 1'b0;
          state    <= ST_COUNT;
        end
        ST_COUNT: begin
          for (int c = 0; c < NUM_CLASSES; c++)
            cnt[c] <= cnt[c] + CNT_W'(votes_q[vote_idx(c, int'(t))]);
          t <= t + 1'b1;
          if (am_start) state <= ST_ARGMAX;
        end
        ST_ARGMAX: if (am_done) begin
          out_class <= am_class;
          out_votes <= am_votes;
          out_tie   <= am_tie;
          out_none  <= (am_votes == '0);
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_forest_vote_accum.sv
// Directed bench for forest_vote_accum: latency, ties, backpressure, reset abort.
module tb_forest_vote_accum;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_tie, out_none;
  logic [19:0] in_votes;
  logic [2:0]  out_class, out_votes;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  forest_vote_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_votes(in_votes),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_votes(out_votes), .out_tie(out_tie), .out_none(out_none)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Wait for out_valid after an accept edge; returns edges elapsed.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic run_vec(input string tag, input logic [19:0] v, input logic [2:0] ec,
                         input logic [2:0] ev, input logic et, input logic en);
    int n;
    chk({tag, "_in_ready_pre"}, in_ready, 1);
    in_votes = v; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_votes = '0;
    chk({tag, "_in_ready_busy"}, in_ready, 0);
    wait_out(n);
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_class"}, out_class, ec);
    chk({tag, "_votes"}, out_votes, ev);
    chk({tag, "_tie"}, out_tie, et);
    chk({tag, "_none"}, out_none, en);
    tick();
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
    chk({tag, "_class_hold"}, out_class, ec);
  endtask

  initial begin
    int n, seen;
    rst = 1'b1; in_valid = 1'b0; in_votes = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_votes", out_votes, 0);
    chk("rst_out_tie", out_tie, 0);
    chk("rst_out_none", out_none, 0);

    // class2 trees 0..2 and class4 tree3
    run_vec("cls2", 20'h80700, 3'd2, 3'd3, 1'b0, 1'b0);
    // class1 bits 4,5 vs class3 bits 14,15
    run_vec("tie13", 20'h0C030, 3'd1, 3'd2, 1'b1, 1'b0);
    run_vec("zero", 20'h00000, 3'd0, 3'd0, 1'b1, 1'b1);

    // Backpressure: class3 all trees held in DONE while a class4 vector waits.
    out_ready = 1'b0;
    in_votes = 20'h0F000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk("bp_latency", n, 9);
    in_votes = 20'h30000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_class_hold", out_class, 3);
      chk("bp_votes_hold", out_votes, 4);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_idle", in_ready, 1);
    tick();
    chk("bp_next_accept", in_ready, 0);
    in_valid = 1'b0; in_votes = '0;
    wait_out(n);
    chk("bp_next_latency", n, 9);
    chk("bp_next_class", out_class, 4);
    chk("bp_next_votes", out_votes, 2);
    chk("bp_next_tie", out_tie, 0);
    tick();

    // Reset during the third COUNT edge aborts the vector.
    in_votes = 20'h000F0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (out_valid) seen++; end
    chk("abort_no_output", seen, 0);
    run_vec("ones", 20'hFFFFF, 3'd0, 3'd4, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
